multicycle_controller: RTL and testbench

//  Multi-cycle control FSM for the 8-bit core; successor to the single-cycle mode/opcode decoder.

---
 rtl/ctrl_pkg.sv | 20 ++
 rtl/ctrl_wait_timer.sv | 27 ++
 rtl/multicycle_controller.sv | 132 +++++++++++++
 tb/tb_multicycle_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control FSM.
package ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT,
      ERROR
   } state_t;

   localparam logic [1:0] MODE_JMP = 2'b00;
   localparam logic [1:0] MODE_LD  = 2'b01;
   localparam logic [1:0] MODE_ST  = 2'b10;
   localparam logic [1:0] MODE_ALU = 2'b11;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory-wait cycle counter; expired flags that the wait limit has been reached.
module ctrl_wait_timer #(
   parameter int unsigned TO_W    = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TO_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + TO_W'(1);
      end
   end

   assign expired = (count == TO_W'(TIMEOUT));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing with
// memory-ready handshake, halt opcode and sticky memory-timeout trap.
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int unsigned         OP_W        = 2,
   parameter logic [OP_W-1:0]     NEG_OPCODE  = 2'b10,
   parameter logic [OP_W-1:0]     HALT_OPCODE = 2'b11,
   parameter int unsigned         TIMEOUT     = 15,
   parameter int unsigned         TO_W        = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      mode,
   input  logic [OP_W-1:0] opcode,
   input  logic            mem_ready,
   input  logic            resume,
   output logic            mem_req,
   output logic            mem_is_fetch,
   output logic            ir_write,
   output logic            pc_inc,
   output logic            pc_write,
   output logic            register_write,
   output logic            memory_write,
   output logic            memory_to_register,
   output logic            alu_negation,
   output logic            val_b_imm_selection,
   output logic            halted,
   output logic            error
);

   state_t          state;
   state_t          state_next;
   logic [1:0]      mode_q;
   logic [OP_W-1:0] op_q;
   logic            waiting;
   logic            expired;

   assign waiting = (state == FETCH) || (state == MEM);

   // Any exit from a wait state (ready or trap) clears the count, so it never wraps.
   ctrl_wait_timer #(
      .TO_W    (TO_W),
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (!waiting || mem_ready || expired),
      .enable  (waiting && !mem_ready),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q <= '0;
         op_q   <= '0;
      end else if (state == DECODE) begin
         mode_q <= mode;
         op_q   <= opcode;
      end
   end

   always_comb begin
      state_next          = state;
      mem_req             = 1'b0;
      mem_is_fetch        = 1'b0;
      ir_write            = 1'b0;
      pc_inc              = 1'b0;
      pc_write            = 1'b0;
      register_write      = 1'b0;
      memory_write        = 1'b0;
      memory_to_register  = 1'b0;
      alu_negation        = 1'b0;
      val_b_imm_selection = 1'b0;
      halted              = 1'b0;
      error               = 1'b0;
      case (state)
         IDLE: state_next = FETCH;
         FETCH: begin
            mem_req      = 1'b1;
            mem_is_fetch = 1'b1;
            ir_write     = mem_ready;
            pc_inc       = mem_ready;
            if (mem_ready) state_next = DECODE;
            else if (expired) state_next = ERROR;
         end
         DECODE: begin
            if (mode == MODE_JMP && opcode == HALT_OPCODE) state_next = HALT;
            else state_next = EXEC;
         end
         EXEC: begin
            alu_negation        = (op_q == NEG_OPCODE) && (mode_q == MODE_ALU);
            val_b_imm_selection = (mode_q == MODE_LD) || (mode_q == MODE_ST);
            case (mode_q)
               MODE_JMP: begin
                  pc_write   = 1'b1;
                  state_next = FETCH;
               end
               MODE_ALU: state_next = WB;
               default:  state_next = MEM;
            endcase
         end
         MEM: begin
            mem_req             = 1'b1;
            val_b_imm_selection = 1'b1;
            memory_write        = (mode_q == MODE_ST);
            if (mem_ready) state_next = (mode_q == MODE_ST) ? FETCH : WB;
            else if (expired) state_next = ERROR;
         end
         WB: begin
            register_write     = 1'b1;
            memory_to_register = (mode_q == MODE_LD);
            state_next         = FETCH;
         end
         HALT: begin
            halted = 1'b1;
            if (resume) state_next = FETCH;
         end
         ERROR: error = 1'b1;
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-cycle expected outputs are generated from instruction-level
// descriptions (mode, opcode, wait counts) and compared against the controller.
module tb_multicycle_controller;

   localparam logic [11:0] O_REQ   = 12'h800;
   localparam logic [11:0] O_FETCH = 12'h400;
   localparam logic [11:0] O_IRW   = 12'h200;
   localparam logic [11:0] O_PCI   = 12'h100;
   localparam logic [11:0] O_PCW   = 12'h080;
   localparam logic [11:0] O_RW    = 12'h040;
   localparam logic [11:0] O_MW    = 12'h020;
   localparam logic [11:0] O_M2R   = 12'h010;
   localparam logic [11:0] O_NEG   = 12'h008;
   localparam logic [11:0] O_IMM   = 12'h004;
   localparam logic [11:0] O_HALT  = 12'h002;
   localparam logic [11:0] O_ERR   = 12'h001;
   localparam int          LIMIT   = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] mode = '0;
   logic [1:0] opcode = '0;
   logic       mem_ready = 1'b0;
   logic       resume = 1'b0;
   logic       mem_req, mem_is_fetch, ir_write, pc_inc, pc_write, register_write;
   logic       memory_write, memory_to_register, alu_negation, val_b_imm_selection;
   logic       halted, error;
   logic [11:0] outs;

   int checks = 0;
   int failures = 0;
   int instr_id = 0;

   typedef struct {
      logic        rdy;
      logic [1:0]  md;
      logic [1:0]  op;
      logic        res;
      logic [11:0] exp;
      int          tag;
   } cyc_t;

   cyc_t plan[$];

   always #5 clk = ~clk;

   multicycle_controller #(
      .OP_W        (2),
      .NEG_OPCODE  (2'b10),
      .HALT_OPCODE (2'b11),
      .TIMEOUT     (15),
      .TO_W        (4)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .mode                (mode),
      .opcode              (opcode),
      .mem_ready           (mem_ready),
      .resume              (resume),
      .mem_req             (mem_req),
      .mem_is_fetch        (mem_is_fetch),
      .ir_write            (ir_write),
      .pc_inc              (pc_inc),
      .pc_write            (pc_write),
      .register_write      (register_write),
      .memory_write        (memory_write),
      .memory_to_register  (memory_to_register),
      .alu_negation        (alu_negation),
      .val_b_imm_selection (val_b_imm_selection),
      .halted              (halted),
      .error               (error)
   );

   assign outs = {mem_req, mem_is_fetch, ir_write, pc_inc, pc_write, register_write,
                  memory_write, memory_to_register, alu_negation, val_b_imm_selection,
                  halted, error};

   function automatic logic [1:0] r2();
      return 2'($urandom_range(0, 3));
   endfunction

   function automatic logic r1();
      return 1'($urandom_range(0, 1));
   endfunction

   // IR fields are randomised outside DECODE to show they are ignored there.
   function automatic void push(logic rdy, logic [1:0] md, logic [1:0] op, logic res,
                                logic [11:0] exp);
      cyc_t c;
      c.rdy = rdy; c.md = md; c.op = op; c.res = res; c.exp = exp; c.tag = instr_id;
      plan.push_back(c);
   endfunction

   function automatic void push_trap();
      for (int i = 0; i < 4; i++) push(r1(), r2(), r2(), r1(), O_ERR);
   endfunction

   // Expected cycles for one instruction; a wait count above LIMIT ends in the trap.
   function automatic void add_instr(logic [1:0] md, logic [1:0] op, int fw, int mw, int hw);
      logic [11:0] e;
      bit is_mem;
      instr_id++;
      is_mem = (md == 2'b01) || (md == 2'b10);
      for (int i = 0; i < fw && i <= LIMIT; i++) push(1'b0, r2(), r2(), r1(), O_REQ | O_FETCH);
      if (fw > LIMIT) begin
         push_trap();
         return;
      end
      push(1'b1, r2(), r2(), 1'b0, O_REQ | O_FETCH | O_IRW | O_PCI);
      push(r1(), md, op, 1'b0, '0);
      if (md == 2'b00 && op == 2'b11) begin
         for (int i = 0; i < hw; i++) push(r1(), r2(), r2(), 1'b0, O_HALT);
         push(r1(), r2(), r2(), 1'b1, O_HALT);
         return;
      end
      e = '0;
      if (md == 2'b11 && op == 2'b10) e |= O_NEG;
      if (is_mem) e |= O_IMM;
      if (md == 2'b00) e |= O_PCW;
      push(r1(), r2(), r2(), 1'b0, e);
      if (is_mem) begin
         e = O_REQ | O_IMM | ((md == 2'b10) ? O_MW : 12'h000);
         for (int i = 0; i < mw && i <= LIMIT; i++) push(1'b0, r2(), r2(), r1(), e);
         if (mw > LIMIT) begin
            push_trap();
            return;
         end
         push(1'b1, r2(), r2(), 1'b0, e);
      end
      if (md == 2'b01 || md == 2'b11)
         push(r1(), r2(), r2(), 1'b0, O_RW | ((md == 2'b01) ? O_M2R : 12'h000));
   endfunction

   task automatic run_plan();
      cyc_t c;
      int step;
      step = 0;
      while (plan.size() > 0) begin
         c = plan.pop_front();
         @(posedge clk);
         #1;
         mem_ready = c.rdy; mode = c.md; opcode = c.op; resume = c.res;
         #1;
         checks++;
         if (outs !== c.exp) begin
            failures++;
            $display("FAIL cycle instr=%0d step=%0d got=%h expected=%h", c.tag, step, outs, c.exp);
         end
         step++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      checks++;
      if (outs !== '0) begin
         failures++;
         $display("FAIL reset_assert got=%h expected=000", outs);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (outs !== '0) begin
         failures++;
         $display("FAIL reset_idle got=%h expected=000", outs);
      end
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (outs !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h expected=000", outs);
      end
      do_reset();
   endtask

   task automatic test_alu();
      add_instr(2'b11, 2'b10, 0, 0, 0);
      run_plan();
   endtask

   task automatic test_load_wait();
      add_instr(2'b01, r2(), 0, 3, 0);
      run_plan();
   endtask

   task automatic test_store_wait();
      add_instr(2'b10, r2(), 2, 5, 0);
      run_plan();
   endtask

   task automatic test_jump_halt();
      add_instr(2'b00, 2'b00, 0, 0, 0);
      add_instr(2'b00, 2'b11, 1, 0, 3);
      add_instr(2'b11, 2'b01, 0, 0, 0);
      run_plan();
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 40; n++)
         add_instr(r2(), r2(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      run_plan();
   endtask

   task automatic test_timeout_boundary();
      add_instr(2'b11, 2'b00, LIMIT, 0, 0);
      add_instr(2'b01, r2(), 0, LIMIT, 0);
      add_instr(2'b10, r2(), LIMIT, LIMIT, 0);
      run_plan();
   endtask

   task automatic test_fetch_timeout();
      add_instr(r2(), r2(), LIMIT + 1, 0, 0);
      run_plan();
      do_reset();
   endtask

   task automatic test_mem_timeout();
      add_instr(2'b10, r2(), 0, LIMIT + 1, 0);
      run_plan();
      do_reset();
      add_instr(2'b11, 2'b10, 0, 0, 0);
      run_plan();
   endtask

   task automatic test_reset_mid_store();
      instr_id++;
      push(1'b1, r2(), r2(), 1'b0, O_REQ | O_FETCH | O_IRW | O_PCI);
      push(1'b0, 2'b10, 2'b01, 1'b0, '0);
      push(1'b0, r2(), r2(), 1'b0, O_IMM);
      push(1'b0, r2(), r2(), 1'b0, O_REQ | O_IMM | O_MW);
      run_plan();
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      #1;
      checks++;
      if (outs !== (O_REQ | O_IMM | O_MW)) begin
         failures++;
         $display("FAIL store_wait_before_reset got=%h expected=%h", outs, O_REQ | O_IMM | O_MW);
      end
      do_reset();
      add_instr(2'b01, r2(), 1, 1, 0);
      run_plan();
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_wait();
      test_store_wait();
      test_jump_halt();
      test_back_to_back();
      test_timeout_boundary();
      test_fetch_timeout();
      test_mem_timeout();
      test_reset_mid_store();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
